fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the instruction decoder. Reads opcode and operand bytes from the 8-bit program memory over a req/ack handshake. Assembles 1- or 2-byte instructions into the 16-bit word the decoder consumes. Presents each instruction with its address under a valid/ready handshake, and honours branch/call/return redirects from execute.

## Interface

Parameters:
- ADDR_W, 16, program address width in bits; the PC wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC loaded on reset.

Ports:
- clk  input  1  clock; everything is on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- fetch_en  input  1  when low, no new instruction fetch starts (halt).
- mem_req  output  1  byte read request.
- mem_addr  output  ADDR_W  byte address of the current request.
- mem_ack  input  1  transfer completes on any cycle with mem_req && mem_ack.
- mem_rdata  input  8  read data, valid on the ack cycle.
- inst_valid  output  1  inst/inst_pc/inst_bytes/inst_next_pc are valid.
- inst_ready  input  1  consumer accepts on a cycle with inst_valid && inst_ready.
- inst  output  16  instruction word, opcode byte in [15:8].
- inst_bytes  output  2  instruction length, 1 or 2.
- inst_pc  output  ADDR_W  address of the opcode byte.
- inst_next_pc  output  ADDR_W  inst_pc + inst_bytes, wrapped; return address for calls.
- redirect  input  1  load a new PC and discard in-flight work.
- redirect_pc  input  ADDR_W  target PC.

## Operation

- States: IDLE, HI (fetching opcode), LO (fetching operand), VALID (holding instruction), DRAIN (waiting out a discarded transfer).
- Length rule:
  - Opcode bit 7 = 0: 1-byte instruction; inst = {opcode, 8'h00}, inst_bytes = 1.
  - Opcode bit 7 = 1: 2-byte instruction; inst = {opcode, operand}, inst_bytes = 2.
  - The operand is read from pc+1 (wrapped).
- IDLE -> HI when fetch_en = 1; mem_addr = pc.
- HI, on ack: capture the opcode.
  - 1-byte -> VALID.
  - 2-byte -> LO with mem_addr = pc+1.
- LO, on ack -> VALID.
- fetch_en gates only the IDLE -> HI transition. A partially fetched instruction always completes.
- VALID, on accept: pc <= inst_next_pc.
  - fetch_en = 1 -> HI.
  - fetch_en = 0 -> IDLE.
- Redirect has highest priority, in every state.
  - HI/LO with no ack in the same cycle -> DRAIN. The request stays asserted until ack; the returned byte is discarded.
  - Ack in the same cycle (HI/LO), or in IDLE/VALID: the byte or held instruction is dropped, pc <= redirect_pc, next state HI (or IDLE if fetch_en = 0).
  - Redirect in the same cycle as an accept: the accept counts, and pc <= redirect_pc rather than inst_next_pc.
  - Redirect during DRAIN: updates the pending target; the latest target wins.
- DRAIN, on ack -> HI at the pending target, or IDLE if fetch_en = 0.
- Discarded bytes never appear on inst.

## Timing

- Reset values: mem_req = 0, mem_addr = RESET_PC, inst_valid = 0, inst = 0, inst_bytes = 1, inst_pc = RESET_PC, inst_next_pc = RESET_PC+1, state IDLE, pc = RESET_PC.
- Reset asserted mid-transfer forces these values next cycle, even without ack. Memory must tolerate an abandoned request.
- All outputs are registered. mem_req and mem_addr change only on the clock edge after an ack, a redirect, or a state entry.
- While mem_req is high without ack, mem_addr and mem_req are stable.
- mem_ack may be asserted in the first cycle of mem_req.
- Zero-wait latency from the HI-entry cycle to inst_valid:
  - 1-byte instruction: 1 cycle.
  - 2-byte instruction: 2 cycles.
- HI is entered the cycle after an accept. Peak throughput: one 1-byte instruction per 2 cycles.
- While inst_valid && !inst_ready: all inst_* outputs are held stable and mem_req = 0.
- Redirect takes effect on the next edge. inst_valid is 0 from the cycle after a redirect until the new instruction completes.

## Test plan

- Reset and 1-byte fetch: RESET_PC = 0, ack tied 1, mem[0] = 0x01.
  - Expect req at addr 0x0000 in the first cycle after reset release.
  - Next cycle: inst_valid = 1, inst = 0x0100, inst_bytes = 1, inst_pc = 0, inst_next_pc = 1.
- 2-byte fetch: pc = 0x0010, mem = 0x88, 0x05.
  - Expect requests to 0x0010 then 0x0011.
  - Then inst = 0x8805, inst_bytes = 2, inst_next_pc = 0x0012.
- Wait states and backpressure: ack delayed 3 cycles per byte, inst_ready low for 5 cycles.
  - mem_addr is stable through each wait.
  - inst_* outputs are held stable and no req is issued while stalled.
  - The next fetch starts the cycle after accept.
- Redirect mid-transfer: redirect to 0x0200 while the HI request waits for ack.
  - req stays high until the delayed ack; that byte is dropped.
  - The next request is addr 0x0200; inst_valid stays 0 until 0x0200 decodes.
- Wrap-around: pc = 0xFFFF, mem[0xFFFF] = 0x90, mem[0x0000] = 0x12.
  - Second request is addr 0x0000.
  - inst = 0x9012, inst_next_pc = 0x0001.
- Halt and reset mid-operation:
  - fetch_en dropped during LO: the instruction completes, then no request after accept.
  - rst_n low mid-request: all outputs are at reset values next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: fetches 1/2-byte instructions over a byte req/ack port and hands them to decode.
//   clk, rst_n (sync, active low), fetch_en (halt when low)
//   mem_req/mem_addr/mem_ack/mem_rdata : program memory byte read handshake
//   inst_valid/inst_ready, inst, inst_bytes, inst_pc, inst_next_pc : decoder handshake
//   redirect/redirect_pc : branch/call/return target from execute
module fetch_unit #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [15:0]       inst,
  output logic [1:0]        inst_bytes,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] inst_next_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);
  typedef enum logic [2:0] {IDLE, HI, LO, VALID, DRAIN} state_t;
  state_t state, state_d;
  logic [ADDR_W-1:0] pc, pc_d, addr_d, ipc_d, inpc_d, restart_pc;
  logic [15:0] inst_d;
  logic [1:0] bytes_d;
  logic [7:0] op, op_d;
  logic req_d, valid_d, restart;
  // The opcode waits in its own register so a dropped 2-byte fetch never shows on inst.
  // In DRAIN, pc already holds the pending redirect target.
  always_comb begin
    state_d = state;
    pc_d = pc;
    req_d = mem_req;
    addr_d = mem_addr;
    valid_d = inst_valid;
    inst_d = inst;
    bytes_d = inst_bytes;
    ipc_d = inst_pc;
    inpc_d = inst_next_pc;
    op_d = op;
    restart = 1'b0;
    restart_pc = pc;
    case (state)
      IDLE: begin
        restart = redirect || fetch_en;
        restart_pc = redirect ? redirect_pc : pc;
      end
      HI: if (redirect) begin
        restart = mem_ack;
        restart_pc = redirect_pc;
        if (!mem_ack) begin
          state_d = DRAIN;
          pc_d = redirect_pc;
        end
      end else if (mem_ack) begin
        op_d = mem_rdata;
        if (mem_rdata[7]) begin
          state_d = LO;
          addr_d = pc + ADDR_W'(1);
        end else begin
          state_d = VALID;
          req_d = 1'b0;
          valid_d = 1'b1;
          inst_d = {mem_rdata, 8'h00};
          bytes_d = 2'd1;
          ipc_d = pc;
          inpc_d = pc + ADDR_W'(1);
        end
      end
      LO: if (redirect) begin
        restart = mem_ack;
        restart_pc = redirect_pc;
        if (!mem_ack) begin
          state_d = DRAIN;
          pc_d = redirect_pc;
        end
      end else if (mem_ack) begin
        state_d = VALID;
        req_d = 1'b0;
        valid_d = 1'b1;
        inst_d = {op, mem_rdata};
        bytes_d = 2'd2;
        ipc_d = pc;
        inpc_d = pc + ADDR_W'(2);
      end
      VALID: begin
        restart = redirect || inst_ready;
        restart_pc = redirect ? redirect_pc : inst_next_pc;
      end
      DRAIN: begin
        if (redirect) pc_d = redirect_pc;
        restart = mem_ack;
        restart_pc = redirect ? redirect_pc : pc;
      end
      default: state_d = IDLE;
    endcase
    if (restart) begin
      state_d = fetch_en ? HI : IDLE;
      pc_d = restart_pc;
      req_d = fetch_en;
      addr_d = restart_pc;
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      op <= 8'h00;
      mem_req <= 1'b0;
      mem_addr <= RESET_PC;
      inst_valid <= 1'b0;
      inst <= 16'h0000;
      inst_bytes <= 2'd1;
      inst_pc <= RESET_PC;
      inst_next_pc <= RESET_PC + ADDR_W'(1);
    end else begin
      state <= state_d;
      pc <= pc_d;
      op <= op_d;
      mem_req <= req_d;
      mem_addr <= addr_d;
      inst_valid <= valid_d;
      inst <= inst_d;
      inst_bytes <= bytes_d;
      inst_pc <= ipc_d;
      inst_next_pc <= inpc_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed tests with a byte-memory responder and a transaction-level fetch model.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n, fetch_en, mem_req, mem_ack, inst_valid, inst_ready, redirect;
  logic [15:0] mem_addr, inst, inst_pc, inst_next_pc, redirect_pc;
  logic [7:0] mem_rdata;
  logic [1:0] inst_bytes;
  int checks = 0, errors = 0, accepts = 0;
  int ack_wait = 0, wcnt = 0;
  logic [7:0] mem [0:65535];
  logic [15:0] acked [$];
  logic [15:0] exp_pc = 16'h0000, hold_addr = 16'h0000;
  logic redir_prev = 1'b0, hold_exp = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_bytes(inst_bytes),
    .inst_pc(inst_pc), .inst_next_pc(inst_next_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] dec(input logic [15:0] a);
    logic [15:0] b;
    b = a + 16'd1;
    return {mem[a], mem[a][7] ? mem[b] : 8'h00};
  endfunction

  function automatic logic [15:0] len(input logic [15:0] a);
    return mem[a][7] ? 16'd2 : 16'd1;
  endfunction

  // Model: the next instruction the decoder must see starts at exp_pc.
  always @(posedge clk) begin
    hold_exp <= rst_n && mem_req && !mem_ack;
    hold_addr <= mem_addr;
    redir_prev <= rst_n && redirect;
    if (rst_n && inst_valid && inst_ready) accepts <= accepts + 1;
    if (!rst_n) exp_pc <= 16'h0000;
    else if (redirect) exp_pc <= redirect_pc;
    else if (inst_valid && inst_ready) exp_pc <= exp_pc + len(exp_pc);
  end

  // Per-cycle compare, then memory response for this cycle.
  always @(negedge clk) begin
    if (hold_exp) begin
      chk("req_hold", {31'd0, mem_req}, 1);
      chk("addr_hold", {16'd0, mem_addr}, {16'd0, hold_addr});
    end
    if (redir_prev) chk("valid_after_redirect", {31'd0, inst_valid}, 0);
    if (inst_valid) begin
      chk("inst", {16'd0, inst}, {16'd0, dec(exp_pc)});
      chk("inst_pc", {16'd0, inst_pc}, {16'd0, exp_pc});
      chk("inst_bytes", {30'd0, inst_bytes}, {16'd0, len(exp_pc)});
      chk("inst_next_pc", {16'd0, inst_next_pc}, {16'd0, exp_pc + len(exp_pc)});
      chk("no_req_while_valid", {31'd0, mem_req}, 0);
    end
    mem_ack = mem_req && wcnt >= ack_wait;
    mem_rdata = mem[mem_addr];
    wcnt = (mem_req && !mem_ack) ? wcnt + 1 : 0;
    if (mem_ack) acked.push_back(mem_addr);
  end

  task automatic jump(input logic [15:0] a);
    redirect = 1'b1;
    redirect_pc = a;
    @(negedge clk);
    redirect = 1'b0;
  endtask

  task automatic accept();
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!inst_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, inst_valid}, 1);
  endtask

  task automatic rst_vals(input string tag);
    chk({tag, "_req"}, {31'd0, mem_req}, 0);
    chk({tag, "_addr"}, {16'd0, mem_addr}, 0);
    chk({tag, "_valid"}, {31'd0, inst_valid}, 0);
    chk({tag, "_inst"}, {16'd0, inst}, 0);
    chk({tag, "_bytes"}, {30'd0, inst_bytes}, 1);
    chk({tag, "_pc"}, {16'd0, inst_pc}, 0);
    chk({tag, "_next"}, {16'd0, inst_next_pc}, 1);
  endtask

  initial begin
    int a0;
    rst_n = 1'b0; fetch_en = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
    redirect_pc = 16'h0000; mem_ack = 1'b0; mem_rdata = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[0] = 8'h01;
    repeat (3) @(negedge clk);
    rst_vals("reset");
    // 1-byte fetch straight out of reset
    rst_n = 1'b1; fetch_en = 1'b1;
    @(negedge clk);
    chk("t1_req", {31'd0, mem_req}, 1);
    chk("t1_addr", {16'd0, mem_addr}, 16'h0000);
    @(negedge clk);
    chk("t1_valid", {31'd0, inst_valid}, 1);
    chk("t1_inst", {16'd0, inst}, 16'h0100);
    chk("t1_bytes", {30'd0, inst_bytes}, 1);
    chk("t1_pc", {16'd0, inst_pc}, 16'h0000);
    chk("t1_next", {16'd0, inst_next_pc}, 16'h0001);
    fetch_en = 1'b0;
    accept();
    chk("t1_halt_req", {31'd0, mem_req}, 0);
    chk("t1_halt_valid", {31'd0, inst_valid}, 0);
    // 2-byte fetch at 0x0010
    mem[16'h0010] = 8'h88; mem[16'h0011] = 8'h05;
    fetch_en = 1'b1;
    jump(16'h0010);
    chk("t2_req0", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0010});
    @(negedge clk);
    chk("t2_req1", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0011});
    @(negedge clk);
    chk("t2_inst", {16'd0, inst}, 16'h8805);
    chk("t2_bytes", {30'd0, inst_bytes}, 2);
    chk("t2_next", {16'd0, inst_next_pc}, 16'h0012);
    fetch_en = 1'b0;
    accept();
    // wait states and backpressure
    ack_wait = 3;
    mem[16'h0020] = 8'h81; mem[16'h0021] = 8'h33; mem[16'h0022] = 8'h05;
    fetch_en = 1'b1;
    jump(16'h0020);
    wait_valid("t3_valid");
    chk("t3_inst", {16'd0, inst}, 16'h8133);
    repeat (5) begin
      @(negedge clk);
      chk("t3_stall_inst", {16'd0, inst}, 16'h8133);
      chk("t3_stall_pc", {16'd0, inst_pc}, 16'h0020);
      chk("t3_stall_req", {31'd0, mem_req}, 0);
    end
    accept();
    chk("t3_next_fetch", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0022});
    wait_valid("t3_valid2");
    chk("t3_inst2", {16'd0, inst}, 16'h0500);
    fetch_en = 1'b0;
    accept();
    // redirect while the opcode request waits
    mem[16'h0030] = 8'h07; mem[16'h0200] = 8'h0A;
    acked.delete();
    fetch_en = 1'b1;
    jump(16'h0030);
    chk("t4_req", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0030});
    jump(16'h0200);
    chk("t4_drain_req", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0030});
    wait_valid("t4_valid");
    chk("t4_inst", {16'd0, inst}, 16'h0A00);
    chk("t4_pc", {16'd0, inst_pc}, 16'h0200);
    chk("t4_nacked", acked.size(), 2);
    if (acked.size() == 2) chk("t4_second_addr", {16'd0, acked[1]}, 16'h0200);
    fetch_en = 1'b0;
    accept();
    // wrap-around
    ack_wait = 0;
    mem[16'hFFFF] = 8'h90; mem[16'h0000] = 8'h12;
    acked.delete();
    fetch_en = 1'b1;
    jump(16'hFFFF);
    wait_valid("t5_valid");
    chk("t5_inst", {16'd0, inst}, 16'h9012);
    chk("t5_next", {16'd0, inst_next_pc}, 16'h0001);
    chk("t5_nacked", acked.size(), 2);
    if (acked.size() == 2) chk("t5_second_addr", {16'd0, acked[1]}, 16'h0000);
    fetch_en = 1'b0;
    accept();
    // halt while the operand is in flight
    ack_wait = 2;
    mem[16'h0040] = 8'hA0; mem[16'h0041] = 8'h5A;
    fetch_en = 1'b1;
    jump(16'h0040);
    for (int n = 0; n < 20 && !(mem_req && mem_addr == 16'h0041); n++) @(negedge clk);
    chk("t6_lo_addr", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0041});
    fetch_en = 1'b0;
    wait_valid("t6_valid");
    chk("t6_inst", {16'd0, inst}, 16'hA05A);
    accept();
    repeat (4) begin
      chk("t6_no_req", {31'd0, mem_req}, 0);
      @(negedge clk);
    end
    // streaming throughput, then redirect in the same cycle as an accept
    ack_wait = 0;
    for (int i = 0; i < 16; i++) mem[16'h0050 + i] = 8'(i + 1);
    mem[16'h0060] = 8'h0B;
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    jump(16'h0050);
    a0 = accepts;
    repeat (8) @(negedge clk);
    chk("t7_throughput", accepts - a0, 4);
    for (int n = 0; n < 10 && !inst_valid; n++) @(negedge clk);
    a0 = accepts;
    jump(16'h0060);
    chk("t7_redir_accept", accepts - a0, 1);
    inst_ready = 1'b0;
    wait_valid("t7_valid");
    chk("t7_pc", {16'd0, inst_pc}, 16'h0060);
    chk("t7_inst", {16'd0, inst}, 16'h0B00);
    fetch_en = 1'b0;
    accept();
    // reset in the middle of a waiting request
    ack_wait = 5;
    fetch_en = 1'b1;
    jump(16'h0070);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_vals("midrst");
    fetch_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle_req", {31'd0, mem_req}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
